pipe_stage_queue: RTL and testbench
===================================

Name: pipe_stage_queue

Overview:
- Parametrised successor to the fixed single-entry stage latches between the IF, ID, EXE, MEM and WB stages.
- Holds up to DEPTH stage payloads in a circular buffer and speaks the core's valid/allowin handshake on both sides.
- Adds a per-stage ready_go stall input, a synchronous flush, and an optional empty-queue fall-through path.
- Drops in between any two stages: a decoupling queue (DEPTH>1) or a classic stage latch (DEPTH=1, FALLTHROUGH=0).

Parameters:
- BUS_WD, 64, payload width in bits (any ≥1; set to the matching *_BUS_WD).
- DEPTH, 2, number of entries, legal 1..8.
- FALLTHROUGH, 0, 1 = empty queue presents in_bus combinationally on out_bus.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clk  in  1  core clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all held entries (branch/exception kill).
- in_valid  in  1  upstream stage has a payload (e.g. fs_to_ds_valid).
- in_bus  in  BUS_WD  upstream payload.
- allowin  out  1  this block accepts in_bus this cycle (e.g. ds_allowin).
- ready_go  in  1  head entry may leave (stage's own stall condition).
- out_valid  out  1  head payload offered downstream.
- out_bus  out  BUS_WD  head payload.
- out_allowin  in  1  downstream allowin.
- count  out  CNT_W  entries currently held.

Behaviour:
- State: DEPTH×BUS_WD entry array, rd_ptr and wr_ptr of $clog2(DEPTH) bits (1 bit minimum), count.
- Reset (resetn=0, async): rd_ptr=0, wr_ptr=0, count=0. Hence out_valid=0 and allowin=1. Entry array is not reset.
- deq = out_valid & out_allowin.
- enq = in_valid & allowin & ~flush, excluding fall-through-consumed input.
- allowin = (count<DEPTH) | (ready_go & out_allowin & count!=0). Full and draining in the same cycle accepts; DEPTH=1 gives exactly the classic stage rule !valid | (ready_go & out_allowin).
- Normal mode, count>0: out_valid=ready_go; out_bus=entry[rd_ptr].
- Normal mode, count=0: out_valid=0; out_bus is don't-care, driven from entry[rd_ptr].
- Fall-through (FALLTHROUGH=1, count=0): out_valid=in_valid & ready_go; out_bus=in_bus.
  - If out_allowin is also 1, the payload passes in zero cycles and is not written.
  - Otherwise it is enqueued.
- Normal mode latency: 1 cycle from enq to out_valid.
- Pointers wrap modulo DEPTH. For non-power-of-2 DEPTH, wrap explicitly at DEPTH-1 → 0.
- count update: +1 on enq only, -1 on deq only, unchanged on both or neither. Never exceeds DEPTH or goes below 0.
- Simultaneous enq and deq when full: write into the slot being vacated (wr_ptr==rd_ptr); count stays DEPTH.
- flush=1:
  - Next edge: count=0, rd_ptr=wr_ptr=0.
  - Same-cycle input is dropped.
  - out_valid is still combinationally driven that cycle; the downstream stage gates with its own flush.
  - deq in the flush cycle has no effect on state.
- ready_go=0 holds the head: out_valid=0 and no dequeue. Enqueue continues until full.
- in_bus is sampled only on enq.
- out_bus is stable while out_valid=1 and out_allowin=0.
- No combinational path from in_valid/in_bus to outputs except the FALLTHROUGH=1 path.
- allowin depends combinationally on out_allowin and ready_go, matching the existing stage chaining.
- Reset asserted mid-transfer discards all entries immediately.

Test Plan:
- Reset, DEPTH=2: hold resetn=0 with in_valid=1 → allowin=1, out_valid=0, count=0. Release, push 0xA then 0xB with out_allowin=0 → count=2, allowin=0, out_bus=0xA.
- Full and drain, DEPTH=2: full of 0xA,0xB; out_allowin=1, in_valid=1, in_bus=0xC → allowin=1, count stays 2. Outputs appear in order 0xA, 0xB, 0xC.
- ready_go stall, DEPTH=3: push 0x1,0x2,0x3 with ready_go=0, out_allowin=1 → out_valid=0, count=3. Raise ready_go → 0x1,0x2,0x3 on three consecutive cycles.
- Flush: count=2 and in_valid=1 with flush=1 → next cycle count=0, out_valid=0. The flush-cycle input never appears at out_bus.
- DEPTH=1 equivalence: random in_valid/out_allowin/ready_go for 1000 cycles against a reference stage latch → identical allowin/out_valid/out_bus every cycle.
- FALLTHROUGH=1, DEPTH=3 (non-power-of-2):
  - Empty, in_bus=0x55, out_allowin=1 → out_valid=1 and out_bus=0x55 same cycle, count stays 0.
  - Then 10 pushes/pops with out_allowin toggling → pointer wrap 2→0 verified, strict FIFO order.

Source files
------------

// File: rtl/pipe_stage_queue.sv
// Inter-stage payload queue speaking the core's valid/allowin handshake on both sides.
// DEPTH=1 with FALLTHROUGH=0 behaves exactly like the classic single-entry stage latch.
module pipe_stage_queue #(
   parameter int BUS_WD      = 64,
   parameter int DEPTH       = 2,
   parameter bit FALLTHROUGH = 1'b0,
   parameter int CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [BUS_WD-1:0] in_bus,
   output logic              allowin,
   input  logic              ready_go,
   output logic              out_valid,
   output logic [BUS_WD-1:0] out_bus,
   input  logic              out_allowin,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [BUS_WD-1:0] entry_q [DEPTH];
   logic [BUS_WD-1:0] headBus;
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              empty, full, fallThru, deq, popHead, enq;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign fallThru = FALLTHROUGH & empty;

   // A full queue still accepts when its head leaves in the same cycle.
   assign allowin  = ~full | (ready_go & out_allowin & ~empty);
   assign deq      = out_valid & out_allowin;
   assign popHead  = deq & ~empty;
   assign enq      = in_valid & allowin & ~flush & ~(fallThru & deq);
   assign count    = count_q;

   always_comb begin
      if (fallThru) begin
         out_valid = in_valid & ready_go;
         out_bus   = in_bus;
      end else begin
         out_valid = ~empty & ready_go;
         out_bus   = headBus;
      end
   end

   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (flush) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
      end else begin
         if (popHead) rdPtr_d = nextPtr(rdPtr_q);
         if (enq)     wrPtr_d = nextPtr(wrPtr_q);
         if (enq & ~popHead)      count_d = count_q + CNT_W'(1);
         else if (~enq & popHead) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   // Payload storage is deliberately left unreset; count alone decides validity.
   generate
      if (DEPTH == 1) begin : gSingle
         assign headBus = entry_q[0];
         always_ff @(posedge clk) begin
            if (enq) entry_q[0] <= in_bus;
         end
      end else begin : gMulti
         assign headBus = entry_q[rdPtr_q];
         always_ff @(posedge clk) begin
            if (enq) entry_q[wrPtr_q] <= in_bus;
         end
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_queue.sv
// Scoreboard bench for pipe_stage_queue: four instances cover DEPTH=2, a DEPTH=3 stall case,
// DEPTH=1 against a reference stage latch, and DEPTH=3 with fall-through.
module tb_pipe_stage_queue;

   localparam int W = 8;

   logic clk = 1'b0;
   logic resetn;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   logic         aFlush, aInValid, aReadyGo, aOutAllowin, aAllowin, aOutValid;
   logic [W-1:0] aInBus, aOutBus;
   logic [1:0]   aCount;
   logic         bFlush, bInValid, bReadyGo, bOutAllowin, bAllowin, bOutValid;
   logic [W-1:0] bInBus, bOutBus;
   logic [1:0]   bCount;
   logic         cFlush, cInValid, cReadyGo, cOutAllowin, cAllowin, cOutValid;
   logic [W-1:0] cInBus, cOutBus;
   logic [0:0]   cCount;
   logic         dFlush, dInValid, dReadyGo, dOutAllowin, dAllowin, dOutValid;
   logic [W-1:0] dInBus, dOutBus;
   logic [1:0]   dCount;

   logic [W-1:0] expA[$];
   logic [W-1:0] expB[$];
   logic [W-1:0] expD[$];

   pipe_stage_queue #(.BUS_WD(W), .DEPTH(2), .FALLTHROUGH(1'b0)) dutA (
      .clk(clk), .resetn(resetn), .flush(aFlush), .in_valid(aInValid), .in_bus(aInBus),
      .allowin(aAllowin), .ready_go(aReadyGo), .out_valid(aOutValid), .out_bus(aOutBus),
      .out_allowin(aOutAllowin), .count(aCount));

   pipe_stage_queue #(.BUS_WD(W), .DEPTH(3), .FALLTHROUGH(1'b0)) dutB (
      .clk(clk), .resetn(resetn), .flush(bFlush), .in_valid(bInValid), .in_bus(bInBus),
      .allowin(bAllowin), .ready_go(bReadyGo), .out_valid(bOutValid), .out_bus(bOutBus),
      .out_allowin(bOutAllowin), .count(bCount));

   pipe_stage_queue #(.BUS_WD(W), .DEPTH(1), .FALLTHROUGH(1'b0)) dutC (
      .clk(clk), .resetn(resetn), .flush(cFlush), .in_valid(cInValid), .in_bus(cInBus),
      .allowin(cAllowin), .ready_go(cReadyGo), .out_valid(cOutValid), .out_bus(cOutBus),
      .out_allowin(cOutAllowin), .count(cCount));

   pipe_stage_queue #(.BUS_WD(W), .DEPTH(3), .FALLTHROUGH(1'b1)) dutD (
      .clk(clk), .resetn(resetn), .flush(dFlush), .in_valid(dInValid), .in_bus(dInBus),
      .allowin(dAllowin), .ready_go(dReadyGo), .out_valid(dOutValid), .out_bus(dOutBus),
      .out_allowin(dOutAllowin), .count(dCount));

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic reportExtra(input string name, input logic [W-1:0] actual);
      checks++;
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=no transfer at %0t", name, actual, $time);
   endtask

   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int qSize(input int which);
      case (which)
         0:       return expA.size();
         1:       return expB.size();
         default: return expD.size();
      endcase
   endfunction

   task automatic waitEmpty(input string name, input int which);
      int n = 0;
      while (qSize(which) != 0 && n < 30) begin
         applyStimulus(1);
         n++;
      end
      checkOutput(name, 32'(qSize(which)), 32'd0);
   endtask

   // Monitors pop the expected head whenever a transfer completes downstream.
   always @(negedge clk) begin
      if (resetn && aOutValid && aOutAllowin) begin
         if (expA.size() == 0) reportExtra("A_extra_out", aOutBus);
         else checkOutput("A_order", 32'(aOutBus), 32'(expA.pop_front()));
      end
      if (resetn && bOutValid && bOutAllowin) begin
         if (expB.size() == 0) reportExtra("B_extra_out", bOutBus);
         else checkOutput("B_order", 32'(bOutBus), 32'(expB.pop_front()));
      end
      if (resetn && dOutValid && dOutAllowin) begin
         if (expD.size() == 0) reportExtra("D_extra_out", dOutBus);
         else checkOutput("D_order", 32'(dOutBus), 32'(expD.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic         refValid, refAllowin;
      logic [W-1:0] refBus;
      int           dCnt[10] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3};

      {aFlush, aInValid, aReadyGo, aOutAllowin, aInBus} = '0;
      {bFlush, bInValid, bReadyGo, bOutAllowin, bInBus} = '0;
      {cFlush, cInValid, cReadyGo, cOutAllowin, cInBus} = '0;
      {dFlush, dInValid, dReadyGo, dOutAllowin, dInBus} = '0;
      resetn = 1'b0;

      // Reset holds the queue empty even with input offered.
      aReadyGo = 1'b1;
      aInValid = 1'b1;
      aInBus   = 8'h77;
      @(negedge clk);
      checkOutput("rst_allowin", 32'(aAllowin), 32'd1);
      checkOutput("rst_out_valid", 32'(aOutValid), 32'd0);
      checkOutput("rst_count", 32'(aCount), 32'd0);
      applyStimulus(1);
      aInValid = 1'b0;
      resetn   = 1'b1;
      applyStimulus(1);

      // Fill DEPTH=2 while downstream is blocked.
      aInValid = 1'b1; aInBus = 8'h0A; expA.push_back(8'h0A);
      @(negedge clk);
      checkOutput("A_push0_allowin", 32'(aAllowin), 32'd1);
      applyStimulus(1);
      aInBus = 8'h0B; expA.push_back(8'h0B);
      @(negedge clk);
      checkOutput("A_push1_allowin", 32'(aAllowin), 32'd1);
      applyStimulus(1);
      aInValid = 1'b0;
      @(negedge clk);
      checkOutput("A_full_count", 32'(aCount), 32'd2);
      checkOutput("A_full_allowin", 32'(aAllowin), 32'd0);
      checkOutput("A_full_out_valid", 32'(aOutValid), 32'd1);
      checkOutput("A_full_head", 32'(aOutBus), 32'h0A);

      // Full and draining in the same cycle still accepts.
      applyStimulus(1);
      aOutAllowin = 1'b1; aInValid = 1'b1; aInBus = 8'h0C; expA.push_back(8'h0C);
      @(negedge clk);
      checkOutput("A_fulldrain_allowin", 32'(aAllowin), 32'd1);
      applyStimulus(1);
      aInValid = 1'b0;
      @(negedge clk);
      checkOutput("A_fulldrain_count", 32'(aCount), 32'd2);
      waitEmpty("A_drain_pending", 0);
      @(negedge clk);
      checkOutput("A_drained_count", 32'(aCount), 32'd0);

      // Flush discards held entries and the same-cycle input.
      applyStimulus(1);
      aOutAllowin = 1'b0; aInValid = 1'b1; aInBus = 8'h11; expA.push_back(8'h11);
      applyStimulus(1);
      aInBus = 8'h22; expA.push_back(8'h22);
      applyStimulus(1);
      aInBus = 8'h33; aFlush = 1'b1;
      expA.delete();
      @(negedge clk);
      checkOutput("A_flush_cycle_count", 32'(aCount), 32'd2);
      checkOutput("A_flush_cycle_out_valid", 32'(aOutValid), 32'd1);
      applyStimulus(1);
      aFlush = 1'b0; aInValid = 1'b0;
      @(negedge clk);
      checkOutput("A_post_flush_count", 32'(aCount), 32'd0);
      checkOutput("A_post_flush_out_valid", 32'(aOutValid), 32'd0);
      checkOutput("A_post_flush_allowin", 32'(aAllowin), 32'd1);
      applyStimulus(1);
      aOutAllowin = 1'b1;
      applyStimulus(3);
      aInValid = 1'b1; aInBus = 8'h44; expA.push_back(8'h44);
      applyStimulus(1);
      aInValid = 1'b0;
      waitEmpty("A_after_flush_pending", 0);

      // DEPTH=3 with ready_go low: fills, then drains on consecutive cycles.
      bOutAllowin = 1'b1;
      bReadyGo    = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         bInValid = 1'b1; bInBus = 8'(i); expB.push_back(8'(i));
         @(negedge clk);
         checkOutput("B_stall_push_allowin", 32'(bAllowin), 32'd1);
         checkOutput("B_stall_out_valid", 32'(bOutValid), 32'd0);
         applyStimulus(1);
      end
      bInValid = 1'b0;
      @(negedge clk);
      checkOutput("B_stalled_out_valid", 32'(bOutValid), 32'd0);
      checkOutput("B_stalled_count", 32'(bCount), 32'd3);
      checkOutput("B_stalled_allowin", 32'(bAllowin), 32'd0);
      applyStimulus(1);
      bReadyGo = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("B_release_out_valid", 32'(bOutValid), 32'd1);
         checkOutput("B_release_count", 32'(bCount), 32'(3 - k));
         applyStimulus(1);
      end
      @(negedge clk);
      checkOutput("B_release_pending", 32'(expB.size()), 32'd0);
      checkOutput("B_release_final_count", 32'(bCount), 32'd0);

      // DEPTH=1 against a classic valid/allowin stage latch.
      refValid = 1'b0;
      refBus   = '0;
      for (int i = 0; i < 1000; i++) begin
         cInValid    = 1'($urandom_range(0, 1));
         cOutAllowin = 1'($urandom_range(0, 1));
         cReadyGo    = ($urandom_range(0, 3) != 0);
         cInBus      = 8'($urandom);
         refAllowin  = ~refValid | (cReadyGo & cOutAllowin);
         @(negedge clk);
         checkOutput("C_allowin", 32'(cAllowin), 32'(refAllowin));
         checkOutput("C_out_valid", 32'(cOutValid), 32'(refValid & cReadyGo));
         if (refValid) checkOutput("C_out_bus", 32'(cOutBus), 32'(refBus));
         if (refAllowin) begin
            if (cInValid) refBus = cInBus;
            refValid = cInValid;
         end
         applyStimulus(1);
      end
      cInValid = 1'b0;

      // Fall-through on an empty DEPTH=3 queue passes the payload in zero cycles.
      dReadyGo = 1'b1; dOutAllowin = 1'b1;
      dInValid = 1'b1; dInBus = 8'h55; expD.push_back(8'h55);
      @(negedge clk);
      checkOutput("D_ft_out_valid", 32'(dOutValid), 32'd1);
      checkOutput("D_ft_out_bus", 32'(dOutBus), 32'h55);
      checkOutput("D_ft_count", 32'(dCount), 32'd0);
      applyStimulus(1);
      dInValid = 1'b0;
      @(negedge clk);
      checkOutput("D_ft_after_count", 32'(dCount), 32'd0);
      applyStimulus(1);

      // Ten pushes with out_allowin dropping on k=1,4,7: nine writes wrap the pointers thrice.
      for (int k = 0; k < 10; k++) begin
         dInValid    = 1'b1;
         dInBus      = 8'(8'h60 + k);
         dOutAllowin = !(k == 1 || k == 4 || k == 7);
         expD.push_back(8'(8'h60 + k));
         @(negedge clk);
         checkOutput("D_wrap_allowin", 32'(dAllowin), 32'd1);
         checkOutput("D_wrap_out_valid", 32'(dOutValid), 32'd1);
         checkOutput("D_wrap_count", 32'(dCount), 32'(dCnt[k]));
         applyStimulus(1);
      end
      dInValid    = 1'b0;
      dOutAllowin = 1'b1;
      waitEmpty("D_wrap_pending", 2);
      @(negedge clk);
      checkOutput("D_final_count", 32'(dCount), 32'd0);

      // Reset in the middle of holding an entry clears it immediately.
      applyStimulus(1);
      aOutAllowin = 1'b0; aInValid = 1'b1; aInBus = 8'h99;
      applyStimulus(1);
      aInValid = 1'b0;
      @(negedge clk);
      checkOutput("A_pre_reset_count", 32'(aCount), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("A_async_reset_count", 32'(aCount), 32'd0);
      checkOutput("A_async_reset_out_valid", 32'(aOutValid), 32'd0);
      applyStimulus(1);
      resetn = 1'b1;
      applyStimulus(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
